// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher sitting between the IF stage and the
// instruction fetch interface. It keeps at most one fetch in flight and
// buffers returned words, together with their addresses, in a DEPTH-entry
// FIFO. A branch redirect flushes the FIFO and discards any in-flight word.
//
// Handshakes:
//   IF side   : the head entry transfers when valid_o & ready_i in the same
//               cycle; the head stays stable while valid_o & !ready_i.
//   Fetch side: fetch_req_o is a one-cycle request pulse with fetch_addr_o;
//               fetch_ack_i is a one-cycle pulse returning fetch_rdata_i for
//               the single outstanding request.
module instr_prefetch_buffer #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  input  logic        ready_i,
  output logic        fetch_req_o,
  output logic [31:0] fetch_addr_o,
  input  logic        fetch_ack_i,
  input  logic [31:0] fetch_rdata_i,
  output logic        busy_o,
  output logic [1:0]  dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ABORT = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   next_addr;
  logic [31:0]   issued_addr;
  logic [31:0]   mem_addr [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic        outstanding;
  logic [31:0] target;
  logic        space;
  logic        slot_free;
  logic        issue;
  logic        push;
  logic        pop;
  logic        unused_branch_lsbs;

  // The two low bits of the redirect target are forced to zero.
  assign unused_branch_lsbs = ^branch_addr_i[1:0];

  // Issue/push/pop decisions for the current cycle.
  always_comb begin
    outstanding = (state != S_IDLE);
    target      = {branch_addr_i[31:2], 2'b00};
    // An outstanding request reserves a slot; a same-cycle pop is not credited.
    space       = ({1'b0, count} + {{CW{1'b0}}, outstanding}) < (CW + 1)'(DEPTH);
    // A new request may go out once nothing is left in flight, which includes
    // the cycle in which the outstanding request is acknowledged.
    slot_free   = (state == S_IDLE) || fetch_ack_i;
    issue       = fetch_en_i && space && slot_free;
    // A word is kept only when it belongs to a live request and no redirect
    // lands in the same cycle.
    push        = (state == S_WAIT) && fetch_ack_i && !branch_i;
    pop         = valid_o && ready_i;
  end

  // Next-state selection; a redirect with no ack turns WAIT into ABORT.
  always_comb begin
    state_nxt = state;
    if (issue)
      state_nxt = S_WAIT;
    else if (fetch_ack_i && (state != S_IDLE))
      state_nxt = S_IDLE;
    else if (branch_i && (state == S_WAIT))
      state_nxt = S_ABORT;
  end

  // Output drive: request pulse, head of FIFO, status.
  always_comb begin
    fetch_req_o  = issue;
    fetch_addr_o = branch_i ? target : next_addr;
    valid_o      = (count != '0);
    rdata_o      = mem_data[rd_ptr];
    addr_o       = mem_addr[rd_ptr];
    busy_o       = outstanding;
    dbg_state    = state;
  end

  // Request FSM and sequential address generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      next_addr   <= BOOT_ADDR;
      issued_addr <= '0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        issued_addr <= fetch_addr_o;
        next_addr   <= fetch_addr_o + 32'd4;
      end else if (branch_i) begin
        next_addr   <= target;
      end
    end
  end

  // Return-word FIFO; a redirect empties it regardless of push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_data[i] <= '0;
      end
    end else if (branch_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_addr[wr_ptr] <= issued_addr;
        mem_data[wr_ptr] <= fetch_rdata_i;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (!push && pop)
        count <= count - CW'(1);
    end
  end

  // The space rule must make a push into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (count != CW'(DEPTH)))
    else $error("push into full prefetch FIFO");

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer (DEPTH=2, BOOT_ADDR=0).
// Inputs change on the falling edge; outputs are sampled 1 time unit later,
// still well ahead of the next rising edge.
module tb_instr_prefetch_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic [31:0] addr_o;
  logic        ready_i;
  logic        fetch_req_o;
  logic [31:0] fetch_addr_o;
  logic        fetch_ack_i;
  logic [31:0] fetch_rdata_i;
  logic        busy_o;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        en;
    logic        rdy;
    logic        br;
    logic [31:0] baddr;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_faddr;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_rdata;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  instr_prefetch_buffer #(.DEPTH(2), .BOOT_ADDR(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_en_i   (fetch_en_i),
    .branch_i     (branch_i),
    .branch_addr_i(branch_addr_i),
    .valid_o      (valid_o),
    .rdata_o      (rdata_o),
    .addr_o       (addr_o),
    .ready_i      (ready_i),
    .fetch_req_o  (fetch_req_o),
    .fetch_addr_o (fetch_addr_o),
    .fetch_ack_i  (fetch_ack_i),
    .fetch_rdata_i(fetch_rdata_i),
    .busy_o       (busy_o),
    .dbg_state    (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic rdy, input logic br, input logic [31:0] baddr,
                     input logic ack, input logic [31:0] rdata,
                     input logic e_req, input logic [31:0] e_faddr,
                     input logic e_valid, input logic [31:0] e_addr, input logic [31:0] e_rdata,
                     input logic e_busy);
    vec_t v;
    v.en = en; v.rdy = rdy; v.br = br; v.baddr = baddr; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_faddr = e_faddr; v.e_valid = e_valid;
    v.e_addr = e_addr; v.e_rdata = e_rdata; v.e_busy = e_busy;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs (called on a falling edge), check, advance.
  task automatic apply(input vec_t v, input string tag);
    fetch_en_i    = v.en;
    ready_i       = v.rdy;
    branch_i      = v.br;
    branch_addr_i = v.baddr;
    fetch_ack_i   = v.ack;
    fetch_rdata_i = v.rdata;
    #1;
    chk({tag, " req"}, {31'd0, fetch_req_o}, {31'd0, v.e_req});
    if (v.e_req) chk({tag, " fetch_addr"}, fetch_addr_o, v.e_faddr);
    chk({tag, " valid"}, {31'd0, valid_o}, {31'd0, v.e_valid});
    if (v.e_valid) begin
      chk({tag, " addr_o"}, addr_o, v.e_addr);
      chk({tag, " rdata_o"}, rdata_o, v.e_rdata);
    end
    chk({tag, " busy"}, {31'd0, busy_o}, {31'd0, v.e_busy});
    @(negedge clk);
  endtask

  task automatic step(input logic en, input logic rdy, input logic br, input logic [31:0] baddr,
                      input logic ack, input logic [31:0] rdata,
                      input logic e_req, input logic [31:0] e_faddr,
                      input logic e_valid, input logic [31:0] e_addr, input logic [31:0] e_rdata,
                      input logic e_busy, input string tag);
    vec_t v;
    v.en = en; v.rdy = rdy; v.br = br; v.baddr = baddr; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_faddr = e_faddr; v.e_valid = e_valid;
    v.e_addr = e_addr; v.e_rdata = e_rdata; v.e_busy = e_busy;
    apply(v, tag);
  endtask

  initial begin
    rst_n = 1'b0; fetch_en_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
    ready_i = 1'b0; fetch_ack_i = 1'b0; fetch_rdata_i = '0;

    // Sequential fetch, ack two cycles after each request, IF always ready.
    //  en rdy br baddr         ack rdata          req faddr         vld addr          rdata          busy
    add(1, 1, 0, 32'h0,        0, 32'h0,          1, 32'h0000_0000, 0, 32'h0,         32'h0,         0);
    add(1, 1, 0, 32'h0,        0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0,         1);
    add(1, 1, 0, 32'h0,        1, 32'hA0A0_0000,  1, 32'h0000_0004, 0, 32'h0,         32'h0,         1);
    add(1, 1, 0, 32'h0,        0, 32'h0,          0, 32'h0,         1, 32'h0000_0000, 32'hA0A0_0000, 1);
    add(1, 1, 0, 32'h0,        1, 32'hA1A1_0001,  1, 32'h0000_0008, 0, 32'h0,         32'h0,         1);
    add(1, 1, 0, 32'h0,        0, 32'h0,          0, 32'h0,         1, 32'h0000_0004, 32'hA1A1_0001, 1);
    add(1, 1, 0, 32'h0,        1, 32'hA2A2_0002,  1, 32'h0000_000C, 0, 32'h0,         32'h0,         1);
    add(0, 1, 0, 32'h0,        0, 32'h0,          0, 32'h0,         1, 32'h0000_0008, 32'hA2A2_0002, 1);
    // fetch_en_i low: outstanding request still completes and pushes
    add(0, 1, 0, 32'h0,        1, 32'hA3A3_0003,  0, 32'h0,         0, 32'h0,         32'h0,         1);
    add(0, 1, 0, 32'h0,        0, 32'h0,          0, 32'h0,         1, 32'h0000_000C, 32'hA3A3_0003, 0);
    // IF stalled: two requests fill the FIFO, then no more until a pop
    add(1, 0, 0, 32'h0,        0, 32'h0,          1, 32'h0000_0010, 0, 32'h0,         32'h0,         0);
    add(1, 0, 0, 32'h0,        0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0,         1);
    add(1, 0, 0, 32'h0,        1, 32'hB0B0_0010,  1, 32'h0000_0014, 0, 32'h0,         32'h0,         1);
    add(1, 0, 0, 32'h0,        0, 32'h0,          0, 32'h0,         1, 32'h0000_0010, 32'hB0B0_0010, 1);
    add(1, 0, 0, 32'h0,        1, 32'hB1B1_0014,  0, 32'h0,         1, 32'h0000_0010, 32'hB0B0_0010, 1);
    add(1, 0, 0, 32'h0,        0, 32'h0,          0, 32'h0,         1, 32'h0000_0010, 32'hB0B0_0010, 0);
    add(1, 0, 0, 32'h0,        0, 32'h0,          0, 32'h0,         1, 32'h0000_0010, 32'hB0B0_0010, 0);
    add(1, 1, 0, 32'h0,        0, 32'h0,          0, 32'h0,         1, 32'h0000_0010, 32'hB0B0_0010, 0);
    add(1, 0, 0, 32'h0,        0, 32'h0,          1, 32'h0000_0018, 1, 32'h0000_0014, 32'hB1B1_0014, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,          0, 32'h0,         1, 32'h0000_0014, 32'hB1B1_0014, 1);
    // Redirect while WAIT, ack three cycles later is dropped
    add(1, 0, 1, 32'h0000_1003, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0014, 32'hB1B1_0014, 1);
    add(1, 0, 0, 32'h0,        0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0,         1);
    add(1, 0, 0, 32'h0,        0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0,         1);
    add(1, 0, 0, 32'h0,        1, 32'hDEAD_DEAD,  1, 32'h0000_1000, 0, 32'h0,         32'h0,         1);
    add(1, 0, 0, 32'h0,        0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0,         1);
    add(1, 0, 0, 32'h0,        1, 32'hC0C0_1000,  1, 32'h0000_1004, 0, 32'h0,         32'h0,         1);
    add(1, 1, 0, 32'h0,        0, 32'h0,          0, 32'h0,         1, 32'h0000_1000, 32'hC0C0_1000, 1);
    // Redirect in the ack cycle: word dropped, target requested at once
    add(1, 0, 1, 32'h0000_2000, 1, 32'h0BAD_0BAD, 1, 32'h0000_2000, 0, 32'h0,         32'h0,         1);
    add(1, 0, 0, 32'h0,        0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0,         1);
    add(1, 0, 0, 32'h0,        1, 32'hD0D0_2000,  1, 32'h0000_2004, 0, 32'h0,         32'h0,         1);
    add(0, 1, 0, 32'h0,        0, 32'h0,          0, 32'h0,         1, 32'h0000_2000, 32'hD0D0_2000, 1);
    add(0, 1, 0, 32'h0,        1, 32'hD1D1_2004,  0, 32'h0,         0, 32'h0,         32'h0,         1);
    add(0, 1, 0, 32'h0,        0, 32'h0,          0, 32'h0,         1, 32'h0000_2004, 32'hD1D1_2004, 0);

    // Reset values
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst valid", {31'd0, valid_o}, 32'd0);
    chk("rst busy", {31'd0, busy_o}, 32'd0);
    chk("rst req", {31'd0, fetch_req_o}, 32'd0);
    chk("rst addr_o", addr_o, 32'h0);
    chk("rst rdata_o", rdata_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i], $sformatf("c%0d", i));

    // Address wrap at the top of the space; redirect with fetch_en_i low
    step(0, 0, 1, 32'hFFFF_FFFF, 0, 32'h0,        0, 32'h0,         0, 32'h0,         32'h0,         0, "wrap0");
    step(1, 0, 0, 32'h0,         0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,         0, "wrap1");
    step(1, 0, 0, 32'h0,         1, 32'hE0E0_FFFC, 1, 32'h0000_0000, 0, 32'h0,        32'h0,         1, "wrap2");
    step(0, 1, 0, 32'h0,         0, 32'h0,        0, 32'h0,         1, 32'hFFFF_FFFC, 32'hE0E0_FFFC, 1, "wrap3");

    // Reset mid-operation: WAIT with one FIFO entry
    step(1, 0, 0, 32'h0,         1, 32'hE1E1_0000, 1, 32'h0000_0004, 0, 32'h0,        32'h0,         1, "mrst0");
    step(0, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,         1, 32'h0000_0000, 32'hE1E1_0000, 1, "mrst1");
    fetch_en_i = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("mrst valid", {31'd0, valid_o}, 32'd0);
    chk("mrst busy", {31'd0, busy_o}, 32'd0);
    chk("mrst req", {31'd0, fetch_req_o}, 32'd0);
    chk("mrst rdata_o", rdata_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_0000, 0, 32'h0,         32'h0,         0, "boot0");
    step(0, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,         0, 32'h0,         32'h0,         1, "boot1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
